// File: rtl/ldst_sequencer.sv
// Execute-phase (T3 onward) Moore sequencer for ld, ldi and st on a shared-bus datapath.
// Every strobe is a flop loaded with the value for the state being entered, so outputs never see inputs combinationally.
module ldst_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic [15:0] rin_sel,
  output logic [15:0] rout_sel,
  output logic        ba_out,
  output logic        c_out,
  output logic        y_in,
  output logic        z_in,
  output logic        zlo_out,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_add,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;

  localparam int             CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_DONE,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [4:0]       r_op;
  logic [3:0]       r_ra;
  logic [CNT_W-1:0] r_wait_cnt;

  logic [15:0] r_rin_sel;
  logic [15:0] r_rout_sel;
  logic        r_ba_out;
  logic        r_c_out;
  logic        r_y_in;
  logic        r_z_in;
  logic        r_zlo_out;
  logic        r_mar_in;
  logic        r_mdr_in;
  logic        r_mdr_out;
  logic        r_mem_read;
  logic        r_mem_write;
  logic        r_alu_add;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_start_legal;
  logic        w_is_ld;
  logic        w_is_ldi;
  logic [15:0] w_ra_onehot;
  logic        w_wait_expired;
  logic        w_unused_ir;

  assign w_start_legal  = (ir[31:27] == OP_LD) || (ir[31:27] == OP_LDI) || (ir[31:27] == OP_ST);
  assign w_is_ld        = (r_op == OP_LD);
  assign w_is_ldi       = (r_op == OP_LDI);
  assign w_ra_onehot    = 16'h0001 << r_ra;
  assign w_wait_expired = (r_wait_cnt == WAIT_LAST);
  // rb and C are consumed by the datapath itself (Grb / BAout, C sign-extension).
  assign w_unused_ir    = ^ir[22:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_ra        <= '0;
      r_wait_cnt  <= '0;
      r_rin_sel   <= '0;
      r_rout_sel  <= '0;
      r_ba_out    <= 1'b0;
      r_c_out     <= 1'b0;
      r_y_in      <= 1'b0;
      r_z_in      <= 1'b0;
      r_zlo_out   <= 1'b0;
      r_mar_in    <= 1'b0;
      r_mdr_in    <= 1'b0;
      r_mdr_out   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_add   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; the later assignment in the case wins, so each state only lists the strobes it raises.
      r_rin_sel   <= '0;
      r_rout_sel  <= '0;
      r_ba_out    <= 1'b0;
      r_c_out     <= 1'b0;
      r_y_in      <= 1'b0;
      r_z_in      <= 1'b0;
      r_zlo_out   <= 1'b0;
      r_mar_in    <= 1'b0;
      r_mdr_in    <= 1'b0;
      r_mdr_out   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_alu_add   <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_op    <= ir[31:27];
            r_ra    <= ir[26:23];
            r_busy  <= 1'b1;
            r_error <= 1'b0;
            if (w_start_legal) begin
              r_state  <= S_T3;
              r_ba_out <= 1'b1;
              r_y_in   <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_error <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end

        S_T3: begin
          r_state   <= S_T4;
          r_c_out   <= 1'b1;
          r_alu_add <= 1'b1;
          r_z_in    <= 1'b1;
        end

        S_T4: begin
          r_state   <= S_T5;
          r_zlo_out <= 1'b1;
          if (w_is_ldi) r_rin_sel <= w_ra_onehot;
          else          r_mar_in  <= 1'b1;
        end

        S_T5: begin
          if (w_is_ldi) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_T6;
            r_wait_cnt <= '0;
            r_mdr_in   <= 1'b1;
            if (w_is_ld) r_mem_read <= 1'b1;
            else         r_rout_sel <= w_ra_onehot;
          end
        end

        S_T6: begin
          if (!w_is_ld) begin
            r_state     <= S_T7;
            r_wait_cnt  <= '0;
            r_mem_write <= 1'b1;
          end else if (mem_ready) begin
            r_state   <= S_T7;
            r_mdr_out <= 1'b1;
            r_rin_sel <= w_ra_onehot;
          end else if (w_wait_expired) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            r_mem_read <= 1'b1;
            r_mdr_in   <= 1'b1;
          end
        end

        S_T7: begin
          if (w_is_ld || mem_ready) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_wait_expired) begin
            r_state <= S_ERR;
            r_error <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_wait_cnt  <= r_wait_cnt + CNT_W'(1);
            r_mem_write <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rin_sel   = r_rin_sel;
  assign rout_sel  = r_rout_sel;
  assign ba_out    = r_ba_out;
  assign c_out     = r_c_out;
  assign y_in      = r_y_in;
  assign z_in      = r_z_in;
  assign zlo_out   = r_zlo_out;
  assign mar_in    = r_mar_in;
  assign mdr_in    = r_mdr_in;
  assign mdr_out   = r_mdr_out;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign alu_add   = r_alu_add;
  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;

endmodule
